data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_pkg.sv | 13 +
 rtl/data_memory_sat_counter.sv | 25 ++
 rtl/data_memory.sv | 112 +++++++++++
 tb/tb_data_memory.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared constants and state encoding for the data memory and its processor.
package data_memory_pkg;

  localparam int AW_DEF = 7;
  localparam int DW_DEF = 32;
  localparam int CNT_W  = 16;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/data_memory_sat_counter.sv
// Enable-driven up counter that sticks at all-ones instead of wrapping.
module sat_counter
  import data_memory_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/data_memory.sv
// Single-port word memory that zero-fills itself after reset, then serves
// one read or one write per cycle with registered read data and usage counters.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 2 ** AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CEN,
  input  logic             WEN,
  input  logic             OEN,
  input  logic [AW-1:0]    A,
  input  logic [DW-1:0]    D,
  output logic [DW-1:0]    Q,
  output logic             ready,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  state_e          r_state;
  state_e          w_nextState;
  logic            r_go;
  logic [AW-1:0]   r_clrPtr;
  logic [DW-1:0]   r_q;
  logic [DW-1:0]   r_mem [DEPTH];

  logic            w_memWe;
  logic [AW-1:0]   w_memAddr;
  logic [DW-1:0]   w_memData;
  logic            w_rdAcc;
  logic            w_wrAcc;

  // The first edge after reset release only arms clearing, so the sweep of
  // all DEPTH words finishes on edge DEPTH+1.
  always_comb begin
    w_nextState = r_state;
    w_memWe     = 1'b0;
    w_memAddr   = A;
    w_memData   = D;
    w_rdAcc     = 1'b0;
    w_wrAcc     = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_go) begin
          w_memWe   = 1'b1;
          w_memAddr = r_clrPtr;
          w_memData = '0;
          if (r_clrPtr == AW'(DEPTH - 1)) begin
            w_nextState = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!CEN) begin
          if (!WEN) begin
            w_memWe = 1'b1;
            w_wrAcc = 1'b1;
          end else begin
            w_rdAcc = 1'b1;
          end
        end
      end
      default: w_nextState = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_INIT;
      r_go     <= 1'b0;
      r_clrPtr <= '0;
      r_q      <= '0;
    end else begin
      r_state <= w_nextState;
      r_go    <= 1'b1;
      if ((r_state == ST_INIT) && r_go) begin
        r_clrPtr <= r_clrPtr + AW'(1);
      end
      if (w_rdAcc) begin
        r_q <= r_mem[A];
      end
    end
  end

  // Storage has no reset; the INIT sweep is what makes it all-zero.
  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[w_memAddr] <= w_memData;
    end
  end

  sat_counter #(.W(CNT_W)) u_rdCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_rdAcc),
    .o_count (rd_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wrCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_wrAcc),
    .o_count (wr_cnt)
  );

  assign Q     = OEN ? '0 : r_q;
  assign ready = (r_state == ST_RUN);

endmodule

// File: tb/tb_data_memory.sv
// Directed checks of data_memory: init sweep timing, read/write, gating,
// reset behaviour and counter saturation.
module tb_data_memory;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          CEN;
  logic          WEN;
  logic          OEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;
  logic          ready;
  logic [15:0]   rd_cnt;
  logic [15:0]   wr_cnt;

  int checks;
  int errors;
  int expRd;
  int expWr;

  data_memory #(.AW(AW), .DW(DW), .DEPTH(128)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .CEN    (CEN),
    .WEN    (WEN),
    .OEN    (OEN),
    .A      (A),
    .D      (D),
    .Q      (Q),
    .ready  (ready),
    .rd_cnt (rd_cnt),
    .wr_cnt (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cen, input logic wen,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    CEN = cen;
    WEN = wen;
    A   = addr;
    D   = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    applyStimulus(1'b0, 1'b0, addr, data);
    tick();
    expWr++;
    applyStimulus(1'b1, 1'b1, '0, '0);
  endtask

  task automatic doRead(input logic [AW-1:0] addr);
    applyStimulus(1'b0, 1'b1, addr, '0);
    tick();
    expRd++;
    applyStimulus(1'b1, 1'b1, '0, '0);
  endtask

  task automatic waitReady(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (ready === 1'b1) break;
      tick();
    end
    checkOutput(tag, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    expRd  = 0;
    expWr  = 0;
    rst_n  = 1'b0;
    OEN    = 1'b0;
    applyStimulus(1'b1, 1'b1, '0, '0);

    #2;
    checkOutput("resetReady", {31'd0, ready}, 32'd0);
    checkOutput("resetQ", Q, 32'd0);
    checkOutput("resetRdCnt", {16'd0, rd_cnt}, 32'd0);
    checkOutput("resetWrCnt", {16'd0, wr_cnt}, 32'd0);

    // Release at t=11; edge 1 is t=15. A write attempt during INIT is ignored.
    #9;
    rst_n = 1'b1;
    for (int i = 1; i <= 128; i++) begin
      tick();
      if (i == 10) applyStimulus(1'b0, 1'b0, 7'd5, 32'd7);
      if (i == 11) applyStimulus(1'b1, 1'b1, '0, '0);
    end
    checkOutput("readyAfter128", {31'd0, ready}, 32'd0);
    checkOutput("initQ", Q, 32'd0);
    tick();
    checkOutput("readyAfter129", {31'd0, ready}, 32'd1);
    checkOutput("initWrCnt", {16'd0, wr_cnt}, 32'd0);

    doRead(7'd5);
    checkOutput("initWriteIgnored", Q, 32'd0);
    for (int a = 0; a < 128; a++) begin
      doRead(AW'(a));
      checkOutput($sformatf("clearRead%0d", a), Q, 32'd0);
    end
    checkOutput("sweepRdCnt", {16'd0, rd_cnt}, 32'(expRd));

    // Fresh reset so the counters start from zero for write/read checks.
    rst_n = 1'b0;
    expRd = 0;
    expWr = 0;
    #3;
    rst_n = 1'b1;
    waitReady("reinitReady1");

    doWrite(7'd13, 32'h0000_0013);
    doRead(7'd13);
    checkOutput("readBack13", Q, 32'd19);
    checkOutput("wrCntOne", {16'd0, wr_cnt}, 32'd1);
    checkOutput("rdCntOne", {16'd0, rd_cnt}, 32'd1);

    OEN = 1'b1;
    #1;
    checkOutput("oenHigh", Q, 32'd0);
    OEN = 1'b0;
    #1;
    checkOutput("oenLow", Q, 32'd19);

    applyStimulus(1'b1, 1'b0, 7'd13, 32'hDEAD_BEEF);
    tick();
    applyStimulus(1'b1, 1'b1, 7'd20, '0);
    tick();
    checkOutput("cenHoldQ", Q, 32'd19);
    checkOutput("cenHoldRd", {16'd0, rd_cnt}, 32'd1);
    checkOutput("cenHoldWr", {16'd0, wr_cnt}, 32'd1);
    doRead(7'd13);
    checkOutput("cenNoWrite", Q, 32'd19);

    doWrite(7'd3, 32'd99);
    doWrite(7'd4, 32'hA5A5_0004);
    doRead(7'd3);
    checkOutput("readBack3", Q, 32'd99);
    doRead(7'd4);
    checkOutput("readBack4", Q, 32'hA5A5_0004);
    checkOutput("wrCntThree", {16'd0, wr_cnt}, 32'(expWr));

    // Asynchronous reset pulse between edges.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstQ", Q, 32'd0);
    checkOutput("asyncRstReady", {31'd0, ready}, 32'd0);
    checkOutput("asyncRstRdCnt", {16'd0, rd_cnt}, 32'd0);
    checkOutput("asyncRstWrCnt", {16'd0, wr_cnt}, 32'd0);
    expRd = 0;
    expWr = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    waitReady("reinitReady2");
    doRead(7'd3);
    checkOutput("reinitClear3", Q, 32'd0);

    // Back-to-back reads up to and past the saturation point.
    applyStimulus(1'b0, 1'b1, 7'd13, '0);
    while (expRd < 65534) begin
      tick();
      expRd++;
    end
    checkOutput("rdCntBelowSat", {16'd0, rd_cnt}, 32'h0000_FFFE);
    tick();
    expRd++;
    checkOutput("rdCntAtSat", {16'd0, rd_cnt}, 32'h0000_FFFF);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(1'b1, 1'b1, '0, '0);
    checkOutput("rdCntHoldSat", {16'd0, rd_cnt}, 32'h0000_FFFF);
    checkOutput("wrCntAfterReads", {16'd0, wr_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
